// File: rtl/shift_seq.sv
// Multi-cycle shift sequencer: splits a 0-255 bit shift into per-cycle SHM/AR/ARX steps.
// Build option: define SHSEQ_BIGSTEP_EN for single 36-bit word moves on long shifts.
module shift_seq (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] count,
  input  logic       longShift,
  input  logic       abort,
  output logic [1:0] shSel,
  output logic [5:0] shCount,
  output logic       loadAR,
  output logic       loadARX,
  output logic       clearAR,
  output logic       clearARX,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {S_IDLE, S_STEP, S_DONE} state_t;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_rem, w_rem_nxt;
  logic       r_lng, w_lng_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_rem   <= 8'd0;
      r_lng   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
      r_lng   <= w_lng_nxt;
    end
  end

  // Outputs depend only on registered state/rem, except abort which masks a step.
  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_lng_nxt   = r_lng;
    shSel       = 2'b00;
    shCount     = 6'd0;
    loadAR      = 1'b0;
    loadARX     = 1'b0;
    clearAR     = 1'b0;
    clearARX    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          w_rem_nxt   = count;
          w_lng_nxt   = longShift;
          w_state_nxt = (count != 8'd0) ? S_STEP : S_DONE;
        end
      end
      S_STEP: begin
        busy = 1'b1;
        if (abort) begin
          w_rem_nxt   = 8'd0;
          w_state_nxt = S_IDLE;
        end else begin
          if (r_lng && r_rem >= 8'd72) begin
            clearAR   = 1'b1;
            clearARX  = 1'b1;
            w_rem_nxt = 8'd0;
          end else if (!r_lng && r_rem >= 8'd36) begin
            clearAR   = 1'b1;
            w_rem_nxt = 8'd0;
`ifdef SHSEQ_BIGSTEP_EN
          end else if (r_rem >= 8'd36) begin
            // Whole-word move: ARX lands in AR, ARX becomes zero.
            shSel     = 2'b10;
            loadAR    = 1'b1;
            clearARX  = 1'b1;
            w_rem_nxt = r_rem - 8'd36;
`else
          end else if (r_rem >= 8'd36) begin
            shCount   = 6'd35;
            loadAR    = 1'b1;
            loadARX   = 1'b1;
            w_rem_nxt = r_rem - 8'd35;
`endif
          end else begin
            shCount   = r_rem[5:0];
            loadAR    = 1'b1;
            loadARX   = r_lng;
            w_rem_nxt = 8'd0;
          end
          w_state_nxt = (w_rem_nxt == 8'd0) ? S_DONE : S_STEP;
        end
      end
      S_DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_shift_seq.sv
// Directed bench for shift_seq; follows SHSEQ_BIGSTEP_EN when it is defined.
module tb_shift_seq;

  logic       clk = 1'b0;
  logic       reset, start, longShift, abort;
  logic [7:0] count;
  logic [1:0] shSel;
  logic [5:0] shCount;
  logic       loadAR, loadARX, clearAR, clearARX, busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  shift_seq dut (
    .clk(clk), .reset(reset), .start(start), .count(count),
    .longShift(longShift), .abort(abort), .shSel(shSel), .shCount(shCount),
    .loadAR(loadAR), .loadARX(loadARX), .clearAR(clearAR), .clearARX(clearARX),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Packed view: {shSel, shCount, loadAR, loadARX, clearAR, clearARX, busy, done}
  function automatic logic [13:0] ev(input logic [1:0] sel, input logic [5:0] cnt,
                                     input logic ar, input logic arx, input logic car,
                                     input logic carx, input logic b, input logic d);
    return {sel, cnt, ar, arx, car, carx, b, d};
  endfunction

  function automatic logic [13:0] obs();
    return {shSel, shCount, loadAR, loadARX, clearAR, clearARX, busy, done};
  endfunction

  task automatic check(input string tag, input logic [13:0] got, input logic [13:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request, let edge 0 sample it, leave the bench in cycle 1.
  task automatic issue(input logic [7:0] c, input logic l);
    start = 1'b1; count = c; longShift = l;
    tick();
    start = 1'b0; count = 8'd0; longShift = 1'b0;
  endtask

  localparam logic [13:0] IDLE_V = 14'h0;
  localparam logic [13:0] DONE_V = 14'h3;

  initial begin
    reset = 1'b1; start = 1'b0; count = 8'd0; longShift = 1'b0; abort = 1'b0;
    #2;
    check("reset_state", obs(), IDLE_V);
    #10 reset = 1'b0;
    tick();
    check("idle_after_reset", obs(), IDLE_V);

    // Asynchronous reset in the middle of a clear step.
    issue(8'd100, 1'b1);
    check("rst_c1_clear", obs(), ev(2'b00, 6'd0, 0, 0, 1, 1, 1, 0));
    #2 reset = 1'b1;
    #1 check("rst_async_outputs", obs(), IDLE_V);
    #1 reset = 1'b0;
    tick();
    check("rst_then_idle", obs(), IDLE_V);

    // Short shift by 7.
    issue(8'd7, 1'b0);
    check("s7_c1", obs(), ev(2'b00, 6'd7, 1, 0, 0, 0, 1, 0));
    tick(); check("s7_c2_done", obs(), DONE_V);
    tick(); check("s7_c3_idle", obs(), IDLE_V);

    // Long shift by 50.
    issue(8'd50, 1'b1);
`ifdef SHSEQ_BIGSTEP_EN
    check("l50_c1", obs(), ev(2'b10, 6'd0, 1, 0, 0, 1, 1, 0));
    tick(); check("l50_c2", obs(), ev(2'b00, 6'd14, 1, 1, 0, 0, 1, 0));
`else
    check("l50_c1", obs(), ev(2'b00, 6'd35, 1, 1, 0, 0, 1, 0));
    tick(); check("l50_c2", obs(), ev(2'b00, 6'd15, 1, 1, 0, 0, 1, 0));
`endif
    tick(); check("l50_c3_done", obs(), DONE_V);
    tick(); check("l50_c4_idle", obs(), IDLE_V);

    // Long clear, count 200.
    issue(8'd200, 1'b1);
    check("l200_c1", obs(), ev(2'b00, 6'd0, 0, 0, 1, 1, 1, 0));
    tick(); check("l200_c2_done", obs(), DONE_V);
    tick();

    // Short clear, count 40.
    issue(8'd40, 1'b0);
    check("s40_c1", obs(), ev(2'b00, 6'd0, 0, 0, 1, 0, 1, 0));
    tick(); check("s40_c2_done", obs(), DONE_V);
    tick();

    // Count 0 goes straight to DONE.
    issue(8'd0, 1'b1);
    check("z_c1_done", obs(), DONE_V);
    tick(); check("z_c2_idle", obs(), IDLE_V);

    // Start while busy is dropped.
    issue(8'd50, 1'b1);
    start = 1'b1; count = 8'd7; longShift = 1'b0;
    tick();
    start = 1'b0;
`ifdef SHSEQ_BIGSTEP_EN
    check("busy_start_c2", obs(), ev(2'b00, 6'd14, 1, 1, 0, 0, 1, 0));
`else
    check("busy_start_c2", obs(), ev(2'b00, 6'd15, 1, 1, 0, 0, 1, 0));
`endif
    tick(); check("busy_start_done", obs(), DONE_V);
    tick(); check("busy_start_idle", obs(), IDLE_V);
    tick(); check("busy_start_not_queued", obs(), IDLE_V);

    // start together with abort in IDLE.
    start = 1'b1; abort = 1'b1; count = 8'd7;
    tick();
    start = 1'b0; abort = 1'b0;
    check("start_abort_c1", obs(), IDLE_V);
    tick(); check("start_abort_c2", obs(), IDLE_V);

    // Long 71, abort during cycle 2.
    issue(8'd71, 1'b1);
`ifdef SHSEQ_BIGSTEP_EN
    check("a71_c1", obs(), ev(2'b10, 6'd0, 1, 0, 0, 1, 1, 0));
`else
    check("a71_c1", obs(), ev(2'b00, 6'd35, 1, 1, 0, 0, 1, 0));
`endif
    tick();
    abort = 1'b1;
    #1 check("a71_c2_masked", obs(), ev(2'b00, 6'd0, 0, 0, 0, 0, 1, 0));
    tick();
    abort = 1'b0;
    check("a71_c3_idle", obs(), IDLE_V);
    tick(); check("a71_c4_no_done", obs(), IDLE_V);

    // Abort in DONE is ignored.
    issue(8'd7, 1'b0);
    tick();
    abort = 1'b1;
    #1 check("abort_in_done", obs(), DONE_V);
    tick();
    abort = 1'b0;
    check("abort_done_idle", obs(), IDLE_V);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
